// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared fetch-packet type and NOP encoding for the decode pipe
package pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
    } fetch_pkt_t;

endpackage

// File: rtl/pipe_fifo.sv
// rtl/pipe_fifo.sv - circular packet buffer with clear-over-everything priority
module pipe_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [W-1:0]               push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push_fire;
    logic          pop_fire;

    assign push_ready = (count_q != CW'(DEPTH));
    assign pop_valid  = (count_q != '0);
    assign push_fire  = push_valid && push_ready && !clr;
    assign pop_fire   = pop_valid && pop_ready && !clr;
    assign pop_data   = mem_q[rd_ptr_q];
    assign count      = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap
            if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_fire && !pop_fire) count_d = count_q + CW'(1);
            if (pop_fire && !push_fire) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - fetch/decode packet buffer with NOP substitution and flush counting
module decode_pipe
    import pipe_pkg::*;
#(
    parameter int               WIDTH = XLEN,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] NOP   = NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       InstrF,
    input  logic [WIDTH-1:0]       PCF,
    input  logic [WIDTH-1:0]       PCPlus4F,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       InstrD,
    output logic [WIDTH-1:0]       PCD,
    output logic [WIDTH-1:0]       PCPlus4D,
    output logic [4:0]             Rs1D,
    output logic [4:0]             Rs2D,
    output logic [4:0]             RdD,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            flush_cnt
);

    localparam int PW = 3 * WIDTH;

    logic [PW-1:0] head_pkt;
    logic [15:0]   flush_cnt_q, flush_cnt_d;
    logic [16:0]   flush_sum;

    pipe_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (flush),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({InstrF, PCF, PCPlus4F}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_pkt),
        .count      (count)
    );

    // Stale buffer contents never leak: an empty pipe presents a bubble
    assign InstrD   = out_valid ? head_pkt[PW-1 -: WIDTH]      : NOP;
    assign PCD      = out_valid ? head_pkt[2*WIDTH-1 -: WIDTH] : '0;
    assign PCPlus4D = out_valid ? head_pkt[WIDTH-1:0]          : '0;
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];
    assign RdD      = InstrD[11:7];

    // The packet offered in the flush cycle is killed too, so it is counted
    assign flush_sum = {1'b0, flush_cnt_q} + 17'(count) + 17'(in_valid);

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush) flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flush_cnt_q <= '0;
        else        flush_cnt_q <= flush_cnt_d;
    end

    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - randomized and directed bench for decode_pipe at DEPTH 2 and 4
module tb_decode_pipe;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] InstrF = '0;
    logic [31:0] PCF = '0;
    logic [31:0] PCPlus4F = '0;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_InstrD, a_PCD, a_PCPlus4D;
    logic [4:0]  a_Rs1D, a_Rs2D, a_RdD;
    logic [1:0]  a_count;
    logic [15:0] a_flush_cnt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_InstrD, b_PCD, b_PCPlus4D;
    logic [4:0]  b_Rs1D, b_Rs2D, b_RdD;
    logic [2:0]  b_count;
    logic [15:0] b_flush_cnt;

    decode_pipe #(.WIDTH(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .out_valid(a_out_valid),
        .out_ready(out_ready), .InstrD(a_InstrD), .PCD(a_PCD), .PCPlus4D(a_PCPlus4D),
        .Rs1D(a_Rs1D), .Rs2D(a_Rs2D), .RdD(a_RdD), .count(a_count), .flush_cnt(a_flush_cnt)
    );

    decode_pipe #(.WIDTH(32), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .out_valid(b_out_valid),
        .out_ready(out_ready), .InstrD(b_InstrD), .PCD(b_PCD), .PCPlus4D(b_PCPlus4D),
        .Rs1D(b_Rs1D), .Rs2D(b_Rs2D), .RdD(b_RdD), .count(b_count), .flush_cnt(b_flush_cnt)
    );

    always #5 clk = ~clk;

    fetch_pkt_t  qa[$];
    fetch_pkt_t  qb[$];
    int          fca = 0;
    int          fcb = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc_next = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_side(input string who, input logic ov, input logic ir,
                              input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [3:0] cnt, input logic [15:0] fc,
                              input int sz, input int depth, input fetch_pkt_t head, input int efc);
        logic [31:0] ei, ep, ep4;
        ei  = (sz != 0) ? head.instr   : NOP_INSTR;
        ep  = (sz != 0) ? head.pc      : 32'h0;
        ep4 = (sz != 0) ? head.pcplus4 : 32'h0;
        check({who, ".out_valid"}, 64'(ov), 64'(sz != 0));
        check({who, ".in_ready"},  64'(ir), 64'(sz != depth));
        check({who, ".InstrD"},    64'(instr), 64'(ei));
        check({who, ".PCD"},       64'(pc), 64'(ep));
        check({who, ".PCPlus4D"},  64'(pc4), 64'(ep4));
        check({who, ".Rs1D"},      64'(rs1), 64'(ei[19:15]));
        check({who, ".Rs2D"},      64'(rs2), 64'(ei[24:20]));
        check({who, ".RdD"},       64'(rd), 64'(ei[11:7]));
        check({who, ".count"},     64'(cnt), 64'(sz));
        check({who, ".flush_cnt"}, 64'(fc), 64'(efc));
    endtask

    task automatic compare_all();
        fetch_pkt_t ha, hb;
        ha = '0;
        hb = '0;
        if (qa.size() != 0) ha = qa[0];
        if (qb.size() != 0) hb = qb[0];
        check_side("d2", a_out_valid, a_in_ready, a_InstrD, a_PCD, a_PCPlus4D, a_Rs1D, a_Rs2D,
                   a_RdD, 4'(a_count), a_flush_cnt, qa.size(), 2, ha, fca);
        check_side("d4", b_out_valid, b_in_ready, b_InstrD, b_PCD, b_PCPlus4D, b_Rs1D, b_Rs2D,
                   b_RdD, 4'(b_count), b_flush_cnt, qb.size(), 4, hb, fcb);
    endtask

    // Reference: a bounded FIFO whose occupancy decides accept/offer, flush wipes it
    task automatic model_next(input fetch_pkt_t qi[$], input int fci, input int depth,
                              output fetch_pkt_t qo[$], output int fco);
        int         sz, s;
        fetch_pkt_t pkt;
        sz  = qi.size();
        qo  = qi;
        fco = fci;
        pkt.instr   = InstrF;
        pkt.pc      = PCF;
        pkt.pcplus4 = PCPlus4F;
        if (flush) begin
            s   = fci + sz + (in_valid ? 1 : 0);
            fco = (s > 65535) ? 65535 : s;
            qo.delete();
        end else begin
            if (sz != 0 && out_ready) void'(qo.pop_front());
            if (in_valid && sz != depth) qo.push_back(pkt);
        end
    endtask

    task automatic step(input logic f, input logic iv, input logic orr, input logic [31:0] instr);
        fetch_pkt_t na[$], nb[$];
        int         nfa, nfb;
        flush     = f;
        in_valid  = iv;
        out_ready = orr;
        InstrF    = instr;
        PCF       = pc_next;
        PCPlus4F  = pc_next + 32'd4;
        #1;
        compare_all();
        model_next(qa, fca, 2, na, nfa);
        model_next(qb, fcb, 4, nb, nfb);
        qa  = na;
        qb  = nb;
        fca = nfa;
        fcb = nfb;
        if (iv) pc_next = pc_next + 32'd4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // streaming through with the consumer always ready
        pc_next = 32'h0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, $urandom);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);

        // stall until full, then drain in order
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'h0);

        // flush with two held and one offered
        step(1'b0, 1'b1, 1'b0, $urandom);
        step(1'b0, 1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, 1'b0, $urandom);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("flush_cnt_after_flush", 64'(a_flush_cnt), 64'd3);

        // field extraction for add a0,t0,a0
        step(1'b0, 1'b1, 1'b0, 32'h00A2_8533);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("fields.Rs1D", 64'(a_Rs1D), 64'd5);
        check("fields.Rs2D", 64'(a_Rs2D), 64'd10);
        check("fields.RdD",  64'(a_RdD),  64'd10);

        // asynchronous reset mid-stream with packets held
        step(1'b0, 1'b1, 1'b0, $urandom);
        check("pre_reset.count", 64'(a_count), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        fca = 0;
        fcb = 0;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 32'h0);

        // randomized traffic, including occasional flushes
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, $urandom);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
